eth_decap: RTL and testbench
============================

Name: eth_decap

Overview:
- Receive-side counterpart of the Eth+IP+UDP encapsulator on the 10G path (clk156 domain).
- Takes 64-bit AXI-Stream frames from the MAC RX and validates the fixed 48-byte Eth+IP+UDP(+6B pad) header against local addresses.
- Strips the header and writes the remaining TLP payload beats into the TLP FIFO, using the same 74-bit word format the encapsulator reads.
- Drops frames that do not match, are runts, or arrive while the FIFO lacks room; each cause is counted.

Parameters:
- eth_addr, 48'h00_11_22_33_44_55, local MAC; h_dest must equal this or FF_FF_FF_FF_FF_FF.
- ip_addr, {8'd192,8'd168,8'd1,8'd111}, local IPv4; daddr must match.
- udp_port, 16'd3776, UDP dest port that must match.
- hdr_beats, 6, header length in 64-bit beats (48 bytes).

Ports:
- clk156  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- s_axis_tvalid  in  1  MAC RX beat valid (no tready; MAC cannot be stalled)
- s_axis_tdata  in  64  wire byte 8*beat+k on tdata[8k+7:8k]
- s_axis_tkeep  in  8  byte enables
- s_axis_tlast  in  1  last beat of frame
- s_axis_tuser  in  1  on the tlast beat, 1 = bad FCS/error
- wr_en  out  1  FIFO write strobe
- din  out  74  {tkeep[73:66], tdata[65:2], tlast[1], tuser[0]}
- full  in  1  FIFO full
- prog_full  in  1  FIFO lacks room for one max-size frame
- rx_ok_cnt  out  32  frames written to the FIFO
- rx_drop_cnt  out  32  frames rejected (mismatch, runt, or no room)
- rx_ovf_cnt  out  32  beats lost because full was asserted mid-frame

Behaviour:
- Reset values: wr_en=0, din=0, all counters=0, state=HDR, beat count=0, match flag=1.
- States:
  - HDR: counts beats 0..5 and ANDs per-beat field checks into the match flag.
  - DATA: forwards payload beats.
  - DROP: discards beats until tlast.
- Beats with s_axis_tvalid=0 never advance state or counters.
- Field checks, bytes big-endian on the wire:
  - beat0: bytes0-5 = eth_addr or broadcast.
  - beat1: bytes4-5 = 08 00; byte6 = 8'h45.
  - beat2: byte7 = 8'd17.
  - beat3: bytes6-7 = ip_addr[31:16].
  - beat4: bytes0-1 = ip_addr[15:0]; bytes4-5 = udp_port.
  - beat5: not checked (UDP checksum + pad).
- IP checksum and lengths are not verified.
- Room check: prog_full is sampled on beat0; the frame is accepted only if prog_full=0.
- Decision on beat5:
  - match, room, and tlast=0: go to DATA.
  - Otherwise: rx_drop_cnt++. If tlast=0 go to DROP, else stay in HDR with count=0.
- Runt: tlast on beats 0..4 increments rx_drop_cnt and restarts HDR on the next beat; nothing is written.
- DATA:
  - Each valid beat is registered and driven one cycle later: wr_en=1 with din built from that beat (latency 1, tkeep/tdata/tlast/tuser passed unchanged, no endian conversion).
  - On the tlast beat: rx_ok_cnt++, return to HDR.
- Overflow: in DATA, full=1 on a cycle that would write causes that beat to be discarded, rx_ovf_cnt++, and wr_en to stay 0. The state still follows tlast.
  - This case is a configuration error: the prog_full threshold must cover the maximum frame.
- DROP: tlast returns to HDR.
- Reset in mid-frame: the block returns to HDR immediately. The remainder of the in-flight frame is parsed as a new header and is expected to fail the checks or be a runt.
- Counters wrap at 2^32.
- Back-to-back frames: the beat after tlast is beat0 of the next frame, with no gap required.

Decomposition:
- Reuse ETH_P_IP, IPVERSION, IP4_PROTO_UDP and ETH_HDR_LEN from ethernet_pkg, ip_pkg and udp_pkg.
- Add tlp_fifo_word_t (the 74-bit packed struct keep/data/last/user) and PEMU_HDR_BEATS=6 to a shared pemu_pkg. The encapsulator and eth_decap both use these.
- No sub-module: the checks are six small compares on the beat counter; counters stay inline.

Test Plan:
- Frame built by the encapsulator (dst 00:11:22:33:44:55, ip 192.168.1.111, dport 3776) with 2 payload beats tdata=64'hA5A5_0000_0000_0001 and 64'h...0002, keep FF/0F, last tuser=0 -> exactly 2 writes one cycle after each input beat; din[65:2] equals the inputs, din[73:66]=FF then 0F, din[1]=0 then 1; rx_ok_cnt=1.
- Same frame with dport 3777 -> no wr_en; rx_drop_cnt=1; the next valid frame sent back-to-back is accepted.
- Broadcast dst FF:FF:FF:FF:FF:FF accepted; ethertype 86DD dropped; protocol 6 dropped -> rx_ok_cnt=1, rx_drop_cnt=2.
- Runt with tlast on beat3 followed immediately by a valid frame -> runt counted in rx_drop_cnt; the valid frame is written in full.
- prog_full=1 on beat0 -> frame dropped; full=1 for one payload beat of an accepted 4-beat-payload frame -> 3 writes, rx_ovf_cnt=1, tlast still written.
- Last payload beat with tuser=1 -> din[0]=1 on the final write; sys_rst asserted mid-DATA -> wr_en=0 and counters=0 the next cycle.

Source files
------------

// File: rtl/ethernet_pkg.sv
// ethernet_pkg: Ethernet II framing constants shared by the 10G path.
package ethernet_pkg;
    localparam logic [15:0] ETH_P_IP    = 16'h0800;
    localparam int          ETH_HDR_LEN = 14;
endpackage

// File: rtl/ip_pkg.sv
// ip_pkg: IPv4 header constants shared by the 10G path.
package ip_pkg;
    localparam logic [3:0] IPVERSION     = 4'd4;
    localparam logic [7:0] IP4_PROTO_UDP = 8'd17;
endpackage

// File: rtl/pemu_pkg.sv
// pemu_pkg: TLP FIFO word format and header geometry shared by encapsulator and decapsulator.
package pemu_pkg;
    localparam int PEMU_HDR_BEATS = 6;
    typedef struct packed {
        logic [7:0]  keep;
        logic [63:0] data;
        logic        last;
        logic        user;
    } tlp_fifo_word_t;
    typedef enum logic [1:0] {HDR, DATA, DROP} decap_state_t;
endpackage

// File: rtl/eth_decap.sv
// eth_decap: validates and strips the 48-byte Eth+IP+UDP header, pushing payload beats into the TLP FIFO.
module eth_decap
    import pemu_pkg::*;
    import ethernet_pkg::ETH_P_IP;
    import ip_pkg::IPVERSION;
    import ip_pkg::IP4_PROTO_UDP;
#(
    parameter logic [47:0] eth_addr  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] ip_addr   = {8'd192, 8'd168, 8'd1, 8'd111},
    parameter logic [15:0] udp_port  = 16'd3776,
    parameter int          hdr_beats = PEMU_HDR_BEATS
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        s_axis_tvalid,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        wr_en,
    output logic [73:0] din,
    input  logic        full,
    input  logic        prog_full,
    output logic [31:0] rx_ok_cnt,
    output logic [31:0] rx_drop_cnt,
    output logic [31:0] rx_ovf_cnt
);
    decap_state_t state;
    logic [2:0]   cnt;
    logic         match;
    logic         room;
    logic         field_ok;
    logic         hdr_match;
    logic         hdr_end;
    logic [63:0]  d;
    logic [47:0]  mac;
    assign d = s_axis_tdata;
    // Wire order is big-endian: byte 0 lands in d[7:0] and holds the field's MSB.
    assign mac = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
    always_comb begin
        field_ok = (cnt == 3'd0) ? (mac == eth_addr || mac == 48'hFFFF_FFFF_FFFF) :
                   (cnt == 3'd1) ? ({d[39:32], d[47:40]} == ETH_P_IP && d[55:48] == {IPVERSION, 4'd5}) :
                   (cnt == 3'd2) ? (d[63:56] == IP4_PROTO_UDP) :
                   (cnt == 3'd3) ? ({d[55:48], d[63:56]} == ip_addr[31:16]) :
                   (cnt == 3'd4) ? ({d[7:0], d[15:8]} == ip_addr[15:0] && {d[39:32], d[47:40]} == udp_port) :
                   1'b1;
        hdr_match = match & field_ok;
        hdr_end   = cnt == 3'(hdr_beats - 1);
    end
    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state       <= HDR;
            cnt         <= '0;
            match       <= 1'b1;
            room        <= 1'b0;
            wr_en       <= 1'b0;
            din         <= '0;
            rx_ok_cnt   <= '0;
            rx_drop_cnt <= '0;
            rx_ovf_cnt  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (s_axis_tvalid) begin
                case (state)
                    HDR: begin
                        if (cnt == 3'd0) room <= !prog_full;
                        if (hdr_end || s_axis_tlast) begin
                            cnt   <= '0;
                            match <= 1'b1;
                            if (hdr_end && hdr_match && room && !s_axis_tlast) state <= DATA;
                            else begin
                                rx_drop_cnt <= rx_drop_cnt + 32'd1;
                                state       <= s_axis_tlast ? HDR : DROP;
                            end
                        end else begin
                            cnt   <= cnt + 3'd1;
                            match <= hdr_match;
                        end
                    end
                    DATA: begin
                        if (full) rx_ovf_cnt <= rx_ovf_cnt + 32'd1;
                        else begin
                            wr_en <= 1'b1;
                            din   <= tlp_fifo_word_t'{s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser};
                        end
                        if (s_axis_tlast) begin
                            rx_ok_cnt <= rx_ok_cnt + 32'd1;
                            state     <= HDR;
                        end
                    end
                    default: if (s_axis_tlast) state <= HDR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eth_decap.sv
// tb_eth_decap: directed scenario tests for eth_decap with hand-computed expectations.
module tb_eth_decap;
    logic        clk156 = 1'b0;
    logic        sys_rst = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        wr_en;
    logic [73:0] din;
    logic        full = 1'b0;
    logic        prog_full = 1'b0;
    logic [31:0] rx_ok_cnt, rx_drop_cnt, rx_ovf_cnt;
    int          vectors = 0;
    int          errors = 0;
    logic [73:0] wq[$];
    localparam logic [47:0] MAC_OK = 48'h00_11_22_33_44_55;
    localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] IP_OK  = {8'd192, 8'd168, 8'd1, 8'd111};

    eth_decap dut (
        .clk156(clk156), .sys_rst(sys_rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .wr_en(wr_en), .din(din), .full(full), .prog_full(prog_full),
        .rx_ok_cnt(rx_ok_cnt), .rx_drop_cnt(rx_drop_cnt), .rx_ovf_cnt(rx_ovf_cnt)
    );

    always #3 clk156 = ~clk156;

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        @(posedge clk156);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (wr_en) wq.push_back(din);
    endtask

    task automatic idle();
        @(posedge clk156);
        #1;
        if (wr_en) wq.push_back(din);
    endtask

    // Sends nb header beats (tlast on the final one when nb < 6); gap_at inserts one idle cycle before that beat.
    task automatic send_hdr(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] pr,
                            input logic [31:0] da, input logic [15:0] dp, input int nb, input int gap_at, input logic pf);
        logic [7:0]  b [48];
        logic [63:0] d;
        for (int i = 0; i < 48; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) b[i] = dst[47-8*i -: 8];
        b[6] = 8'h02; b[11] = 8'h01;
        b[12] = et[15:8]; b[13] = et[7:0];
        b[14] = 8'h45; b[17] = 8'h2C; b[22] = 8'h40; b[23] = pr;
        b[24] = 8'hB7; b[25] = 8'h1C;
        b[26] = 8'd192; b[27] = 8'd168; b[28] = 8'd1; b[29] = 8'd10;
        for (int i = 0; i < 4; i++) b[30+i] = da[31-8*i -: 8];
        b[34] = 8'h0E; b[35] = 8'hC0;
        b[36] = dp[15:8]; b[37] = dp[7:0];
        b[39] = 8'h18;
        for (int k = 0; k < nb; k++) begin
            if (k == gap_at) idle();
            for (int j = 0; j < 8; j++) d[8*j +: 8] = b[8*k+j];
            prog_full = (k == 0) ? pf : 1'b0;
            send_beat(d, 8'hFF, nb < 6 && k == nb - 1, 1'b0);
        end
        prog_full = 1'b0;
    endtask

    function automatic logic [73:0] pay_word(input int i, input int n, input logic ul);
        return {(i == n) ? 8'h0F : 8'hFF, 64'hA5A5_0000_0000_0000 + 64'(i), i == n, (i == n) & ul};
    endfunction

    task automatic send_pay(input int n, input logic ul, input int full_at);
        logic [73:0] w;
        for (int i = 1; i <= n; i++) begin
            w = pay_word(i, n, ul);
            full = (i == full_at);
            send_beat(w[65:2], w[73:66], w[1], w[0]);
        end
        full = 1'b0;
    endtask

    task automatic good_frame(input int n);
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3776, 6, -1, 1'b0);
        send_pay(n, 1'b0, 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk156);
        #1;
        sys_rst = 1'b0;
        vectors += 5;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
        if (din !== 74'd0) begin errors++; $display("FAIL reset_din got %h want 0", din); end
        if (rx_ok_cnt !== 32'd0) begin errors++; $display("FAIL reset_ok got %0d want 0", rx_ok_cnt); end
        if (rx_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", rx_drop_cnt); end
        if (rx_ovf_cnt !== 32'd0) begin errors++; $display("FAIL reset_ovf got %0d want 0", rx_ovf_cnt); end
    endtask

    task automatic test_good();
        wq.delete();
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3776, 6, -1, 1'b0);
        vectors += 1;
        if (wq.size() != 0) begin errors++; $display("FAIL good_hdr_writes got %0d want 0", wq.size()); end
        send_beat(64'hA5A5_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        vectors += 2;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL good_lat1_wr got %0b want 1", wr_en); end
        if (din !== {8'hFF, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0}) begin errors++; $display("FAIL good_din0 got %h want %h", din, {8'hFF, 64'hA5A5_0000_0000_0001, 2'b00}); end
        send_beat(64'hA5A5_0000_0000_0002, 8'h0F, 1'b1, 1'b0);
        vectors += 3;
        if (din !== {8'h0F, 64'hA5A5_0000_0000_0002, 1'b1, 1'b0}) begin errors++; $display("FAIL good_din1 got %h want %h", din, {8'h0F, 64'hA5A5_0000_0000_0002, 2'b10}); end
        if (wq.size() != 2) begin errors++; $display("FAIL good_writes got %0d want 2", wq.size()); end
        if (rx_ok_cnt !== 32'd1) begin errors++; $display("FAIL good_ok got %0d want 1", rx_ok_cnt); end
        idle();
        vectors += 1;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL good_idle_wr got %0b want 0", wr_en); end
    endtask

    task automatic test_mismatch_back_to_back();
        wq.delete();
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3777, 6, -1, 1'b0);
        send_pay(2, 1'b0, 0);
        vectors += 2;
        if (wq.size() != 0) begin errors++; $display("FAIL dport_writes got %0d want 0", wq.size()); end
        if (rx_drop_cnt !== 32'd1) begin errors++; $display("FAIL dport_drop got %0d want 1", rx_drop_cnt); end
        good_frame(2);
        vectors += 3;
        if (wq.size() != 2) begin errors++; $display("FAIL b2b_writes got %0d want 2", wq.size()); end
        else if (wq[1] !== pay_word(2, 2, 1'b0)) begin errors++; $display("FAIL b2b_din got %h want %h", wq[1], pay_word(2, 2, 1'b0)); end
        if (rx_ok_cnt !== 32'd2) begin errors++; $display("FAIL b2b_ok got %0d want 2", rx_ok_cnt); end
    endtask

    task automatic test_variants();
        wq.delete();
        send_hdr(MAC_BC, 16'h0800, 8'd17, IP_OK, 16'd3776, 6, 3, 1'b0);
        send_pay(2, 1'b0, 0);
        vectors += 2;
        if (wq.size() != 2) begin errors++; $display("FAIL bcast_writes got %0d want 2", wq.size()); end
        if (rx_ok_cnt !== 32'd3) begin errors++; $display("FAIL bcast_ok got %0d want 3", rx_ok_cnt); end
        wq.delete();
        send_hdr(MAC_OK, 16'h86DD, 8'd17, IP_OK, 16'd3776, 6, -1, 1'b0);
        send_pay(2, 1'b0, 0);
        send_hdr(MAC_OK, 16'h0800, 8'd6, IP_OK, 16'd3776, 6, -1, 1'b0);
        send_pay(2, 1'b0, 0);
        send_hdr(MAC_OK, 16'h0800, 8'd17, 32'hC0A8_0170, 16'd3776, 6, -1, 1'b0);
        send_pay(1, 1'b0, 0);
        vectors += 3;
        if (wq.size() != 0) begin errors++; $display("FAIL variant_writes got %0d want 0", wq.size()); end
        if (rx_drop_cnt !== 32'd4) begin errors++; $display("FAIL variant_drop got %0d want 4", rx_drop_cnt); end
        if (rx_ok_cnt !== 32'd3) begin errors++; $display("FAIL variant_ok got %0d want 3", rx_ok_cnt); end
    endtask

    task automatic test_runt();
        wq.delete();
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3776, 4, -1, 1'b0);
        vectors += 1;
        if (rx_drop_cnt !== 32'd5) begin errors++; $display("FAIL runt_drop got %0d want 5", rx_drop_cnt); end
        good_frame(2);
        vectors += 3;
        if (wq.size() != 2) begin errors++; $display("FAIL runt_next_writes got %0d want 2", wq.size()); end
        else if (wq[0] !== pay_word(1, 2, 1'b0)) begin errors++; $display("FAIL runt_next_din got %h want %h", wq[0], pay_word(1, 2, 1'b0)); end
        if (rx_ok_cnt !== 32'd4) begin errors++; $display("FAIL runt_next_ok got %0d want 4", rx_ok_cnt); end
    endtask

    task automatic test_room();
        wq.delete();
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3776, 6, -1, 1'b1);
        send_pay(2, 1'b0, 0);
        vectors += 2;
        if (wq.size() != 0) begin errors++; $display("FAIL progfull_writes got %0d want 0", wq.size()); end
        if (rx_drop_cnt !== 32'd6) begin errors++; $display("FAIL progfull_drop got %0d want 6", rx_drop_cnt); end
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3776, 6, -1, 1'b0);
        send_pay(4, 1'b0, 2);
        vectors += 5;
        if (wq.size() != 3) begin errors++; $display("FAIL ovf_writes got %0d want 3", wq.size()); end
        else begin
            if (wq[1] !== pay_word(3, 4, 1'b0)) begin errors++; $display("FAIL ovf_skip got %h want %h", wq[1], pay_word(3, 4, 1'b0)); end
            if (wq[2][1] !== 1'b1) begin errors++; $display("FAIL ovf_last got %0b want 1", wq[2][1]); end
        end
        if (rx_ovf_cnt !== 32'd1) begin errors++; $display("FAIL ovf_cnt got %0d want 1", rx_ovf_cnt); end
        if (rx_ok_cnt !== 32'd5) begin errors++; $display("FAIL ovf_ok got %0d want 5", rx_ok_cnt); end
    endtask

    task automatic test_tuser_and_reset();
        wq.delete();
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3776, 6, -1, 1'b0);
        send_pay(2, 1'b1, 0);
        vectors += 2;
        if (wq.size() != 2) begin errors++; $display("FAIL tuser_writes got %0d want 2", wq.size()); end
        else if (wq[1] !== pay_word(2, 2, 1'b1)) begin errors++; $display("FAIL tuser_din got %h want %h", wq[1], pay_word(2, 2, 1'b1)); end
        send_hdr(MAC_OK, 16'h0800, 8'd17, IP_OK, 16'd3776, 6, -1, 1'b0);
        send_beat(64'hA5A5_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        sys_rst = 1'b1;
        send_beat(64'hA5A5_0000_0000_0002, 8'hFF, 1'b0, 1'b0);
        sys_rst = 1'b0;
        vectors += 4;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr got %0b want 0", wr_en); end
        if (rx_ok_cnt !== 32'd0) begin errors++; $display("FAIL midrst_ok got %0d want 0", rx_ok_cnt); end
        if (rx_drop_cnt !== 32'd0) begin errors++; $display("FAIL midrst_drop got %0d want 0", rx_drop_cnt); end
        if (rx_ovf_cnt !== 32'd0) begin errors++; $display("FAIL midrst_ovf got %0d want 0", rx_ovf_cnt); end
        wq.delete();
        good_frame(3);
        vectors += 2;
        if (wq.size() != 3) begin errors++; $display("FAIL postrst_writes got %0d want 3", wq.size()); end
        if (rx_ok_cnt !== 32'd1) begin errors++; $display("FAIL postrst_ok got %0d want 1", rx_ok_cnt); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_mismatch_back_to_back();
        test_variants();
        test_runt();
        test_room();
        test_tuser_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
